decimal_output_unit: RTL and testbench

Converts a 32-bit word written by the CPU to the display port into decimal digits for `seven_seg_unit`, with the two digits beyond the 8-digit tube signalled on the overflow LEDs. It is the output-side counterpart of the keypad path: keypad entry turns decimal digits into binary, and this block turns binary back into decimal. It sits between `data_mem` (display write strobe and data) and `seven_seg_unit` and the LEDs, and reports busy and completion to `hazard_unit`.

---
 rtl/decimal_output_unit_pkg.sv | 36 +++
 rtl/decimal_output_unit_bcd_dabble_step.sv | 24 ++
 rtl/decimal_output_unit.sv | 140 ++++++++++++++
 tb/tb_decimal_output_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/decimal_output_unit_pkg.sv
// Shared definitions for the binary-to-decimal display path: widths,
// FSM encodings, double-dabble step count and the digit-lighting rule.
package decimal_output_unit_pkg;

    localparam int ISA_WIDTH         = 32;
    localparam int DIGIT_CNT         = 8;
    localparam int DIGIT_RADIX_WIDTH = 4;
    localparam int OVERFLOW_CNT      = 2;

    localparam int DISP_W   = DIGIT_CNT * DIGIT_RADIX_WIDTH;
    localparam int NIB_CNT  = DIGIT_CNT + OVERFLOW_CNT;
    localparam int BCD_W    = NIB_CNT * DIGIT_RADIX_WIDTH;
    localparam int STEP_CNT = 32;
    localparam int STEP_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CONVERT = 2'b01,
        ST_DONE    = 2'b10
    } state_e;

    // A tube digit is lit when it, or any more significant digit (overflow
    // digits included), is nonzero; digit 0 is always lit so 0 shows "0".
    function automatic logic [DIGIT_CNT-1:0] lit_mask(input logic [BCD_W-1:0] bcd);
        logic                 any_nz;
        logic [DIGIT_CNT-1:0] m;
        any_nz = 1'b0;
        m      = '0;
        for (int i = NIB_CNT - 1; i >= 0; i--) begin
            any_nz = any_nz | (|bcd[i*DIGIT_RADIX_WIDTH +: DIGIT_RADIX_WIDTH]);
            if (i < DIGIT_CNT) m[i] = any_nz | (i == 0);
        end
        return m;
    endfunction

endpackage

// File: rtl/decimal_output_unit_bcd_dabble_step.sv
// One combinational double-dabble step: every BCD nibble >= 5 gets +3,
// then the BCD register shifts left by one, taking in the binary msb.
module bcd_dabble_step
    import decimal_output_unit_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_in,
    input  logic             bin_msb,
    output logic [BCD_W-1:0] bcd_out
);

    logic [BCD_W-1:0] adj;

    for (genvar i = 0; i < NIB_CNT; i++) begin : g_nib
        localparam int LO = i * DIGIT_RADIX_WIDTH;
        // Nibble is at most 9, so +3 never carries out of the nibble.
        assign adj[LO +: DIGIT_RADIX_WIDTH] =
            (bcd_in[LO +: DIGIT_RADIX_WIDTH] >= 4'd5)
                ? bcd_in[LO +: DIGIT_RADIX_WIDTH] + 4'd3
                : bcd_in[LO +: DIGIT_RADIX_WIDTH];
    end

    assign bcd_out = {adj[BCD_W-2:0], bin_msb};

endmodule

// File: rtl/decimal_output_unit.sv
// Converts a CPU display write into 8 BCD tube digits plus two overflow
// LEDs using a 32-step serial double-dabble. Busy covers the whole
// conversion; a one-cycle complete pulse marks fresh digits.
// Optional macro OUTPUT_SIGNED_EN: treat the word as two's complement,
// convert its magnitude and light the negative LED.
module decimal_output_unit
    import decimal_output_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 output_enable,
    input  logic [ISA_WIDTH-1:0] write_data,
    output logic                 output_busy,
    output logic                 output_complete,
    output logic [DISP_W-1:0]    display_digits,
    output logic [DIGIT_CNT-1:0] digit_mask,
    output logic                 overflow_9th,
    output logic                 overflow_10th,
    output logic                 negative
);

    state_e               state_q, state_d;
    logic [ISA_WIDTH-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [BCD_W-1:0]     bcd_step;
    logic [STEP_W-1:0]    step_q, step_d;
    logic                 complete_q, complete_d;
    logic [DISP_W-1:0]    digits_q, digits_d;
    logic [DIGIT_CNT-1:0] mask_q, mask_d;
    logic                 ovf9_q, ovf9_d;
    logic                 ovf10_q, ovf10_d;
`ifdef OUTPUT_SIGNED_EN
    logic                 neg_pend_q, neg_pend_d;
    logic                 negative_q, negative_d;
`endif

    bcd_dabble_step u_step (
        .bcd_in  (bcd_q),
        .bin_msb (bin_q[ISA_WIDTH-1]),
        .bcd_out (bcd_step)
    );

    // Next-state, datapath and output-register updates for the conversion FSM.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        step_d     = step_q;
        complete_d = 1'b0;
        digits_d   = digits_q;
        mask_d     = mask_q;
        ovf9_d     = ovf9_q;
        ovf10_d    = ovf10_q;
`ifdef OUTPUT_SIGNED_EN
        neg_pend_d = neg_pend_q;
        negative_d = negative_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (output_enable) begin
`ifdef OUTPUT_SIGNED_EN
                    neg_pend_d = write_data[ISA_WIDTH-1];
                    bin_d      = write_data[ISA_WIDTH-1]
                                 ? (~write_data) + ISA_WIDTH'(1)
                                 : write_data;
`else
                    bin_d      = write_data;
`endif
                    bcd_d      = '0;
                    step_d     = '0;
                    state_d    = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                bin_d  = {bin_q[ISA_WIDTH-2:0], 1'b0};
                bcd_d  = bcd_step;
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(STEP_CNT - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                digits_d   = bcd_q[DISP_W-1:0];
                mask_d     = lit_mask(bcd_q);
                ovf9_d     = |bcd_q[BCD_W-1:DISP_W];
                ovf10_d    = |bcd_q[BCD_W-1:BCD_W-DIGIT_RADIX_WIDTH];
`ifdef OUTPUT_SIGNED_EN
                negative_d = neg_pend_q;
`endif
                complete_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            step_q     <= '0;
            complete_q <= 1'b0;
            digits_q   <= '0;
            mask_q     <= DIGIT_CNT'(1);
            ovf9_q     <= 1'b0;
            ovf10_q    <= 1'b0;
`ifdef OUTPUT_SIGNED_EN
            neg_pend_q <= 1'b0;
            negative_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            step_q     <= step_d;
            complete_q <= complete_d;
            digits_q   <= digits_d;
            mask_q     <= mask_d;
            ovf9_q     <= ovf9_d;
            ovf10_q    <= ovf10_d;
`ifdef OUTPUT_SIGNED_EN
            neg_pend_q <= neg_pend_d;
            negative_q <= negative_d;
`endif
        end
    end

    assign output_busy     = (state_q != ST_IDLE);
    assign output_complete = complete_q;
    assign display_digits  = digits_q;
    assign digit_mask      = mask_q;
    assign overflow_9th    = ovf9_q;
    assign overflow_10th   = ovf10_q;
`ifdef OUTPUT_SIGNED_EN
    assign negative        = negative_q;
`else
    assign negative        = 1'b0;
`endif

endmodule

// File: tb/tb_decimal_output_unit.sv
// Bench for decimal_output_unit: a cycle-level reference model built from
// plain decimal arithmetic, checked every cycle, plus literal expectations.
module tb_decimal_output_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        output_enable = 1'b0;
    logic [31:0] write_data = '0;
    logic        output_busy, output_complete;
    logic [31:0] display_digits;
    logic [7:0]  digit_mask;
    logic        overflow_9th, overflow_10th, negative;

    int n_checks = 0;
    int n_pass   = 0;

    decimal_output_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .output_enable   (output_enable),
        .write_data      (write_data),
        .output_busy     (output_busy),
        .output_complete (output_complete),
        .display_digits  (display_digits),
        .digit_mask      (digit_mask),
        .overflow_9th    (overflow_9th),
        .overflow_10th   (overflow_10th),
        .negative        (negative)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_busy;      // cycles of conversion still ahead
    logic [31:0] m_val;
    logic        m_cmp, m_o9, m_o10, m_neg, m_live = 1'b0;
    logic [31:0] m_dig;
    logic [7:0]  m_mask;

    function automatic longint unsigned pow10(input int k);
        longint unsigned p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    task automatic model_show(input logic [31:0] v);
        longint unsigned mag;
        mag   = {32'd0, v};
        m_neg = 1'b0;
`ifdef OUTPUT_SIGNED_EN
        if (v[31]) begin
            mag   = 64'h1_0000_0000 - {32'd0, v};
            m_neg = 1'b1;
        end
`endif
        for (int k = 0; k < 8; k++) begin
            m_dig[k*4 +: 4] = 4'((mag / pow10(k)) % 10);
            m_mask[k]       = (k == 0) || (mag >= pow10(k));
        end
        m_o9  = mag >= pow10(8);
        m_o10 = mag >= pow10(9);
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_cmp = 0; m_dig = 0; m_mask = 8'h01;
            m_o9 = 0; m_o10 = 0; m_neg = 0; m_live = 1;
        end else begin
            m_cmp = 0;
            if (m_busy == 0) begin
                if (output_enable) begin
                    m_busy = 33;
                    m_val  = write_data;
                end
            end else begin
                m_busy--;
                if (m_busy == 0) begin
                    model_show(m_val);
                    m_cmp = 1;
                end
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            logic [44:0] act, exp;
            act = {output_busy, output_complete, display_digits, digit_mask,
                   overflow_9th, overflow_10th, negative};
            exp = {(m_busy != 0), m_cmp, m_dig, m_mask, m_o9, m_o10, m_neg};
            n_checks++;
            if (act === exp) n_pass++;
            else $display("FAIL cycle @%0t: got %h expected %h", $time, act, exp);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic write(input logic [31:0] v);
        @(negedge clk);
        output_enable = 1'b1;
        write_data    = v;
        @(negedge clk);
        output_enable = 1'b0;
    endtask

    // Waits for the complete pulse (bounded), counting busy cycles from accept.
    task automatic wait_done(input string name, input logic [31:0] dig, input logic [7:0] mask,
                             input logic o9, input logic o10, input logic neg,
                             output int busy_cnt);
        bit seen = 0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (output_complete) begin seen = 1; break; end
            if (output_busy) busy_cnt++;
            @(negedge clk);
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL %s timeout: got no complete pulse, required one within 40 cycles", name);
        end else begin
            check(name, {display_digits, digit_mask, overflow_9th, overflow_10th, negative},
                        {dig, mask, o9, o10, neg});
        end
    endtask

    initial begin
        int bc;
        int extra;
        logic sneg;
`ifdef OUTPUT_SIGNED_EN
        sneg = 1'b1;
`else
        sneg = 1'b0;
`endif
        // 1. reset
        repeat (2) @(negedge clk);
        check("reset", {output_busy, output_complete, display_digits, digit_mask,
                        overflow_9th, overflow_10th, negative},
                       {1'b0, 1'b0, 32'h0, 8'h01, 3'b000});
        rst_n = 1'b1;

        // 2. eight-digit value
        write(32'd12345678);
        wait_done("val_12345678", 32'h12345678, 8'hFF, 0, 0, 0, bc);
        check("busy_cycles", 64'(bc), 64'd33);
        @(negedge clk);
        check("complete_1cycle", {output_complete, output_busy}, 2'b00);

        // 3. leading-zero blanking
        write(32'd907);
        wait_done("val_907", 32'h00000907, 8'h07, 0, 0, 0, bc);
        write(32'd0);
        wait_done("val_0", 32'h0, 8'h01, 0, 0, 0, bc);

        // 4. overflow LEDs
        write(32'hFFFF_FFFF);
        if (sneg) wait_done("val_ffffffff", 32'h00000001, 8'h01, 0, 0, 1, bc);
        else      wait_done("val_ffffffff", 32'h94967295, 8'hFF, 1, 1, 0, bc);
        write(32'd123456789);
        wait_done("val_123456789", 32'h23456789, 8'hFF, 1, 0, 0, bc);
        write(32'h8000_0000);
        wait_done("val_80000000", 32'h47483648, 8'hFF, 1, 1, sneg, bc);

        // 5. write while busy is dropped
        write(32'd5);
        repeat (9) @(negedge clk);
        output_enable = 1'b1;
        write_data    = 32'd9;
        @(negedge clk);
        output_enable = 1'b0;
        wait_done("busy_drop", 32'h00000005, 8'h01, 0, 0, 0, bc);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (output_complete) extra++;
        end
        check("no_second_complete", 64'(extra), 64'd0);

        // 6. reset mid-conversion
        write(32'd4321);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_reset", {output_busy, output_complete, display_digits, digit_mask,
                            overflow_9th, overflow_10th, negative},
                           {1'b0, 1'b0, 32'h0, 8'h01, 3'b000});
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (output_complete) extra++;
        end
        check("no_abort_complete", 64'(extra), 64'd0);
        write(32'd42);
        wait_done("val_42", 32'h00000042, 8'h03, 0, 0, 0, bc);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
